// File: rtl/ra_host_sdr_64x72.sv
// Command front end for the 64x72 SDR test array: issues reads/writes on
// registered enables and returns read data in order through a credited FIFO.
module ra_host_sdr_64x72 #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_val,
  output logic        cmd_rdy,
  input  logic        cmd_wr,
  input  logic [5:0]  cmd_adr,
  input  logic [71:0] cmd_dat,
  output logic        rsp_val,
  input  logic        rsp_rdy,
  output logic [71:0] rsp_dat,
  output logic        rsp_port,
  output logic        busy,
  output logic        rd_enb_0,
  output logic [5:0]  rd_adr_0,
  input  logic [71:0] rd_dat_0,
  output logic        rd_enb_1,
  output logic [5:0]  rd_adr_1,
  input  logic [71:0] rd_dat_1,
  output logic        wr_enb_0,
  output logic [5:0]  wr_adr_0,
  output logic [71:0] wr_dat_0
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic              sel;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_port;

  logic [71:0]           fifo_dat [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_port;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic       hazard;
  logic       accept;
  logic       push;
  logic       pop;
  logic [7:0] outstanding;

  // Every read holds one credit from issue until its FIFO entry is popped.
  always_comb begin
    outstanding = 8'(count) + 8'(rd_enb_0) + 8'(rd_enb_1);
    for (int i = 0; i < RD_LAT; i++) begin
      outstanding = outstanding + 8'(pipe_vld[i]);
    end
  end

  assign hazard   = cmd_val & ~cmd_wr & wr_enb_0 & (cmd_adr == wr_adr_0);
  assign cmd_rdy  = (outstanding < 8'(FIFO_DEPTH)) & ~hazard;
  assign accept   = cmd_val & cmd_rdy;
  assign push     = pipe_vld[RD_LAT-1];
  assign rsp_val  = (count != '0);
  assign pop      = rsp_val & rsp_rdy;
  assign rsp_dat  = fifo_dat[rd_ptr];
  assign rsp_port = fifo_port[rd_ptr];
  assign busy     = (|pipe_vld) | rd_enb_0 | rd_enb_1 | rsp_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel      <= 1'b0;
      wr_enb_0 <= 1'b0;
      wr_adr_0 <= '0;
      wr_dat_0 <= '0;
      rd_enb_0 <= 1'b0;
      rd_adr_0 <= '0;
      rd_enb_1 <= 1'b0;
      rd_adr_1 <= '0;
    end else begin
      wr_enb_0 <= accept & cmd_wr;
      rd_enb_0 <= accept & ~cmd_wr & ~sel;
      rd_enb_1 <= accept & ~cmd_wr & sel;
      if (accept & cmd_wr) begin
        wr_adr_0 <= cmd_adr;
        wr_dat_0 <= cmd_dat;
      end
      if (accept & ~cmd_wr) begin
        if (sel) rd_adr_1 <= cmd_adr;
        else     rd_adr_0 <= cmd_adr;
        sel <= ~sel;
      end
    end
  end

  // Stage 0 follows the issue register, so the last stage lines up with rd_dat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld  <= '0;
      pipe_port <= '0;
    end else begin
      pipe_vld[0]  <= rd_enb_0 | rd_enb_1;
      pipe_port[0] <= rd_enb_1;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_port[i] <= pipe_port[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_dat[i] <= '0;
      end
      fifo_port <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (push) begin
        fifo_dat[wr_ptr]  <= pipe_port[RD_LAT-1] ? rd_dat_1 : rd_dat_0;
        fifo_port[wr_ptr] <= pipe_port[RD_LAT-1];
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
